// File: rtl/fp32_divider_if.sv
// Start/done handshake and operand/result bus for the fp32 divider.
interface fp32_divider_if;
    logic        start;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] output_z;
    logic        done;
    logic        busy;

    modport master (output start, input_a, input_b, input output_z, done, busy);
    modport slave  (input start, input_a, input_b, output output_z, done, busy);
endinterface

// File: rtl/fp32_divider.sv
// Multi-cycle IEEE-754 single-precision divider z = a / b, restoring mantissa
// division one quotient bit per cycle, round to nearest even, denormal aware.
module fp32_divider (
    input  logic           clk,
    input  logic           rst,
    fp32_divider_if.slave  bus
);
    localparam int unsigned QBITS = 27;
    localparam int unsigned MW    = 25;
    localparam int unsigned EW    = 10;
    localparam int unsigned CW    = 5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_NORM   = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_POST   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [31:0]             a_q, a_d, b_q, b_d;
    logic                    sign_q, sign_d;
    logic [MW-1:0]           ma_q, ma_d, mb_q, mb_d, rem_q, rem_d;
    logic signed [EW-1:0]    ea_q, ea_d, eb_q, eb_d, ze_q, ze_d;
    logic [QBITS-1:0]        q_q, q_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;
    logic [31:0]             z_q, z_d;
    logic [31:0]             output_z_q, output_z_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    // Operand decode from the latched words
    logic                    sign_c;
    logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MW-1:0]           a_ma, b_ma;
    logic signed [EW-1:0]    a_ea, b_ea;

    assign sign_c = a_q[31] ^ b_q[31];
    assign a_nan  = (&a_q[30:23]) &  (|a_q[22:0]);
    assign b_nan  = (&b_q[30:23]) &  (|b_q[22:0]);
    assign a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    assign b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    assign a_zero = ~(|a_q[30:0]);
    assign b_zero = ~(|b_q[30:0]);
    assign a_ma   = {1'b0, |a_q[30:23], a_q[22:0]};
    assign b_ma   = {1'b0, |b_q[30:23], b_q[22:0]};
    assign a_ea   = (a_q[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, a_q[30:23]});
    assign b_ea   = (b_q[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, b_q[30:23]});

    // One normalisation step for each unnormalised operand
    logic [MW-1:0]           ma_n, mb_n;
    logic signed [EW-1:0]    ea_n, eb_n;

    assign ma_n = ma_q[23] ? ma_q : (ma_q << 1);
    assign mb_n = mb_q[23] ? mb_q : (mb_q << 1);
    assign ea_n = ma_q[23] ? ea_q : (ea_q - 10'sd1);
    assign eb_n = mb_q[23] ? eb_q : (eb_q - 10'sd1);

    // Restoring division step
    logic                    div_ge;
    logic [MW-1:0]           div_diff;

    assign div_ge   = (rem_q >= mb_q);
    assign div_diff = div_ge ? (rem_q - mb_q) : rem_q;

    // Post-normalise, then denormalise with sticky collection when ze <= 0
    logic [QBITS-1:0]        post_q;
    logic signed [EW-1:0]    post_ze, post_sh;
    logic [CW-1:0]           post_amt;
    logic                    post_lost;

    assign post_q    = q_q[QBITS-1] ? q_q : (q_q << 1);
    assign post_ze   = q_q[QBITS-1] ? ze_q : (ze_q - 10'sd1);
    assign post_sh   = 10'sd1 - post_ze;
    assign post_amt  = (post_sh > 10'sd27) ? 5'd27 : post_sh[CW-1:0];
    assign post_lost = |(post_q & ~({QBITS{1'b1}} << post_amt));

    // Round to nearest even; carry out of the mantissa bumps the exponent
    logic [23:0]             rnd_mant;
    logic                    rnd_inc;
    logic [MW-1:0]           rnd_sum;
    logic [23:0]             rnd_mant_f;
    logic signed [EW-1:0]    rnd_ze;
    logic [7:0]              rnd_exp;

    assign rnd_mant   = q_q[26:3];
    assign rnd_inc    = q_q[2] & (sticky_q | q_q[1] | q_q[0] | rnd_mant[0]);
    assign rnd_sum    = {1'b0, rnd_mant} + MW'(rnd_inc);
    assign rnd_mant_f = rnd_sum[24] ? rnd_sum[24:1] : rnd_sum[23:0];
    assign rnd_ze     = rnd_sum[24] ? (ze_q + 10'sd1) : ze_q;
    assign rnd_exp    = (rnd_ze == 10'sd0) ? {7'd0, rnd_mant_f[23]} : rnd_ze[7:0];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        ze_d       = ze_q;
        rem_d      = rem_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        z_d        = z_q;
        output_z_d = output_z_q;
        done_d     = done_q;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.input_a;
                    b_d     = bus.input_b;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d = sign_c;
                ma_d   = a_ma;
                mb_d   = b_ma;
                ea_d   = a_ea;
                eb_d   = b_ea;
                if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                    z_d     = 32'h7FC0_0000;
                    state_d = S_DONE;
                end else if (a_inf | b_zero) begin
                    z_d     = {sign_c, 8'hFF, 23'd0};
                    state_d = S_DONE;
                end else if (a_zero | b_inf) begin
                    z_d     = {sign_c, 31'd0};
                    state_d = S_DONE;
                end else if (a_ma[23] & b_ma[23]) begin
                    rem_d   = a_ma;
                    ze_d    = a_ea - b_ea + 10'sd127;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                ma_d = ma_n;
                mb_d = mb_n;
                ea_d = ea_n;
                eb_d = eb_n;
                if (ma_n[23] & mb_n[23]) begin
                    rem_d   = ma_n;
                    ze_d    = ea_n - eb_n + 10'sd127;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                q_d   = {q_q[QBITS-2:0], div_ge};
                rem_d = div_diff << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CW'(QBITS - 1)) begin
                    state_d = S_POST;
                end
            end
            S_POST: begin
                if (post_ze <= 10'sd0) begin
                    q_d      = post_q >> post_amt;
                    ze_d     = 10'sd0;
                    sticky_d = post_lost | (rem_q != '0);
                end else begin
                    q_d      = post_q;
                    ze_d     = post_ze;
                    sticky_d = (rem_q != '0);
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (rnd_ze >= 10'sd255) begin
                    z_d = {sign_q, 8'hFF, 23'd0};
                end else begin
                    z_d = {sign_q, rnd_exp, rnd_mant_f[22:0]};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                output_z_d = z_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            ea_q       <= '0;
            eb_q       <= '0;
            ze_q       <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            z_q        <= '0;
            output_z_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            ze_q       <= ze_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            z_q        <= z_d;
            output_z_q <= output_z_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.output_z = output_z_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule
